// File: rtl/ahb_resp_mux_n.sv
// ahb_resp_mux_n: NS:1 AHB-Lite slave-response mux with built-in default slave.
// The address-phase select is captured on every edge where HREADY is high and
// held through the data phase. That captured select AND-OR muxes the slave
// responses back to the master. When no slave is selected, a small default
// slave FSM owns HREADY/HRESP and returns the two-cycle ERROR response for
// unmapped NONSEQ/SEQ transfers.
module ahb_resp_mux_n #(
  parameter int NS = 16,
  parameter int DW = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NS-1:0]    hsel_i,
  input  logic [1:0]       htrans_i,
  input  logic [NS*DW-1:0] hrdata_s,
  input  logic [NS-1:0]    hreadyout_s,
  input  logic [NS-1:0]    hresp_s,
  output logic [DW-1:0]    hrdata,
  output logic             hready,
  output logic             hresp,
  output logic [NS-1:0]    dsel_o,
  output logic             sel_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  // True when more than one bit of the select vector is set.
  function automatic logic multi_hot(input logic [NS-1:0] v);
    return (v & (v - NS'(1))) != '0;
  endfunction

  logic [NS-1:0] dsel_r;
  logic          sel_err_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic          unm_s;
  logic          dflt_ready_s;
  logic          dflt_resp_s;
  logic          slv_ready_s;
  logic          slv_resp_s;
  logic [DW-1:0] slv_rdata_s;

  // Active transfer (NONSEQ/SEQ) that no slave claims.
  assign unm_s = (hsel_i == '0) && htrans_i[1];

  // Data-phase select and decoder-fault flag, updated only on capture edges.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_r    <= '0;
      sel_err_r <= 1'b0;
    end else if (hready) begin
      dsel_r    <= hsel_i;
      sel_err_r <= multi_hot(hsel_i);
    end else begin
      dsel_r    <= dsel_r;
      sel_err_r <= sel_err_r;
    end
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Default-slave next state; ERR2 is itself a capture edge, so back-to-back
  // unmapped transfers go straight to ERR1 again.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hready && unm_s) begin
          state_nxt_s = ST_ERR1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      ST_ERR2: begin
        if (unm_s) begin
          state_nxt_s = ST_ERR1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Default-slave response: wait+ERROR, then ready+ERROR.
  always_comb begin
    dflt_ready_s = 1'b1;
    dflt_resp_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
      end
      ST_ERR1: begin
        dflt_ready_s = 1'b0;
        dflt_resp_s  = 1'b1;
      end
      ST_ERR2: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b1;
      end
      default: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
      end
    endcase
  end

  // Single-level AND-OR mux of the selected slaves; multi-hot ORs them.
  always_comb begin
    slv_rdata_s = '0;
    for (int i = 0; i < NS; i++) begin
      slv_rdata_s = slv_rdata_s | ({DW{dsel_r[i]}} & hrdata_s[i*DW +: DW]);
    end
    slv_ready_s = |(dsel_r & hreadyout_s);
    slv_resp_s  = |(dsel_r & hresp_s);
  end

  // Hand HREADY/HRESP to the default slave when nothing is selected.
  always_comb begin
    hrdata = slv_rdata_s;
    if (dsel_r != '0) begin
      hready = slv_ready_s;
      hresp  = slv_resp_s;
    end else begin
      hready = dflt_ready_s;
      hresp  = dflt_resp_s;
    end
  end

  assign dsel_o  = dsel_r;
  assign sel_err = sel_err_r;

endmodule
